// File: rtl/seg_defs_pkg.sv
// Shared seven-segment definitions: hex glyph table, inactive levels and digit count.
// Glyphs and OFF constants are active-high; polarity is applied where the pins are driven.
package seg_defs_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  // Active-high "nothing lit" levels.
  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam logic [3:0] SEL_OFF = 4'h0;

  // Index = nibble value, bits = gfedcba.
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic [3:0]  dp;
    logic [15:0] data;
  } disp_word_t;

endpackage

// File: rtl/hex_display_scanner_if.sv
// Front-panel bus between the word source and the display scanner.
// The master supplies the word to show; the slave drives the panel pins.
interface hex_display_scanner_if;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        load;
  logic [3:0]  sel;
  logic [7:0]  seg;
  logic        frame_done;

  modport master (output data_in, dp_in, load, input sel, seg, frame_done);
  modport slave  (input data_in, dp_in, load, output sel, seg, frame_done);
endinterface

// File: rtl/hex7seg_decode.sv
// Combinational nibble + dp to seven-segment pattern, including output polarity.
// blank_i suppresses the glyph but leaves the decimal point under dp_i control.
module hex7seg_decode
  import seg_defs_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  logic [7:0] pattern;

  always_comb begin
    pattern = SEG_OFF;
    if (!blank_i) begin
      pattern[6:0] = GLYPH_TABLE[nibble_i];
    end
    pattern[7] = dp_i;
    seg_o      = SEG_ACTIVE_LOW ? ~pattern : pattern;
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed 4-digit hex display scanner with frame-aligned word updates.
// Optional macro SEG_LEADING_ZERO_BLANK_EN blanks digits above the top nonzero nibble.
module hex_display_scanner
  import seg_defs_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLANK_CYCLES   = 500,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  hex_display_scanner_if.slave bus
);

  localparam int unsigned       PrescW   = $clog2(SCAN_DIV);
  localparam logic [PrescW-1:0] PrescMax = PrescW'(SCAN_DIV - 1);
  localparam logic [7:0]        SegRst   = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [3:0]        SelRst   = SEL_ACTIVE_LOW ? ~SEL_OFF : SEL_OFF;

  logic [PrescW-1:0] presc_q, presc_d;
  logic [1:0]        digit_q, digit_d;
  disp_word_t        shadow_q, shadow_d;
  disp_word_t        display_q, display_d;
  logic              pending_q, pending_d;
  logic [3:0]        sel_q, sel_d;
  logic [7:0]        seg_q, seg_d;
  logic              frame_done_q, frame_done_d;

  logic       wrap, boundary;
  disp_word_t in_word;
  logic       slot_blank, lead_zero;
  logic [3:0] cur_nib;
  logic [3:0] sel_on;

  // Scan timing and word staging.
  always_comb begin
    wrap     = (presc_q == PrescMax);
    boundary = wrap && (digit_q == 2'd3);
    presc_d  = wrap ? '0 : presc_q + 1'b1;
    digit_d  = wrap ? digit_q + 2'd1 : digit_q;
    in_word  = {bus.dp_in, bus.data_in};

    shadow_d  = shadow_q;
    pending_d = pending_q;
    display_d = display_q;
    if (boundary) begin
      // A load landing on the boundary goes straight to the display.
      pending_d = 1'b0;
      if (bus.load) begin
        display_d = in_word;
      end else if (pending_q) begin
        display_d = shadow_q;
      end
    end else if (bus.load) begin
      shadow_d  = in_word;
      pending_d = 1'b1;
    end
    frame_done_d = boundary;
  end

  // Pin values for the current slot, registered one cycle later.
  always_comb begin
    slot_blank = (32'(presc_q) < BLANK_CYCLES);
    cur_nib    = display_q.data[{digit_q, 2'b00} +: 4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    lead_zero  = (digit_q != 2'd0) && ((display_q.data >> {digit_q, 2'b00}) == 16'h0000);
`else
    lead_zero  = 1'b0;
`endif
    sel_on     = 4'b0001 << digit_q;
    sel_d      = slot_blank ? SEL_OFF : sel_on;
    if (SEL_ACTIVE_LOW) begin
      sel_d = ~sel_d;
    end
  end

  hex7seg_decode #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_decode (
    .nibble_i(cur_nib),
    .dp_i    (!slot_blank && display_q.dp[digit_q]),
    .blank_i (slot_blank || lead_zero),
    .seg_o   (seg_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      digit_q      <= 2'd0;
      shadow_q     <= '0;
      display_q    <= '0;
      pending_q    <= 1'b0;
      sel_q        <= SelRst;
      seg_q        <= SegRst;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      digit_q      <= digit_d;
      shadow_q     <= shadow_d;
      display_q    <= display_d;
      pending_q    <= pending_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Randomized bench for hex_display_scanner against a frame-level reference model.
// Model: each frame shows the last word loaded during the previous frame (else unchanged).
module tb_hex_display_scanner;

  localparam int unsigned D     = 4;
  localparam int unsigned B     = 1;
  localparam int unsigned FRAME = 4 * D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hex_display_scanner_if bus();

  hex_display_scanner #(
    .SCAN_DIV      (D),
    .BLANK_CYCLES  (B),
    .SEG_ACTIVE_LOW(1'b1),
    .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          n = 0;
  logic [19:0] disp_n = '0;
  logic [19:0] disp_prev = '0;
  logic [19:0] last_val = '0;
  bit          last_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (model cycle %0d)", tag, got, exp, n);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Outputs seen in cycle n reflect the scan position and display of cycle n-1.
  task automatic check_outputs();
    logic [3:0] exp_sel;
    logic [7:0] exp_seg;
    logic       exp_fd;
    logic [3:0] onehot;
    int         m, phase, slot;
    logic [3:0] v;
    logic       dpb, lz;
    exp_sel = 4'hF;
    exp_seg = 8'hFF;
    exp_fd  = 1'b0;
    if (n > 0) begin
      m      = n - 1;
      phase  = m % D;
      slot   = (m / D) % 4;
      exp_fd = ((m % FRAME) == FRAME - 1);
      if (phase >= B) begin
        onehot  = 4'b0001 << slot;
        exp_sel = ~onehot;
        v       = 4'((disp_prev[15:0] >> (4 * slot)) & 16'h000F);
        dpb     = disp_prev[16 + slot];
`ifdef SEG_LEADING_ZERO_BLANK_EN
        lz      = (slot > 0) && ((disp_prev[15:0] >> (4 * slot)) == 16'h0000);
`else
        lz      = 1'b0;
`endif
        exp_seg = ~{dpb, (lz ? 7'h00 : glyph(v))};
      end
    end
    check_eq("sel", 32'(bus.sel), 32'(exp_sel));
    check_eq("seg", 32'(bus.seg), 32'(exp_seg));
    check_eq("frame_done", 32'(bus.frame_done), 32'(exp_fd));
  endtask

  // One clock: check, drive this cycle's load, advance the model, clock.
  task automatic step(input bit ld, input logic [15:0] d, input logic [3:0] p);
    check_outputs();
    bus.load    = ld;
    bus.data_in = d;
    bus.dp_in   = p;
    if (ld) begin
      last_val   = {p, d};
      last_valid = 1'b1;
    end
    disp_prev = disp_n;
    n++;
    if ((n % FRAME) == 0 && last_valid) begin
      disp_n     = last_val;
      last_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst      = 1'b1;
    bus.load = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("rst_sel", 32'(bus.sel), 32'h0000000F);
      check_eq("rst_seg", 32'(bus.seg), 32'h000000FF);
      check_eq("rst_frame_done", 32'(bus.frame_done), 32'h0);
    end
    rst        = 1'b0;
    n          = 0;
    disp_n     = '0;
    disp_prev  = '0;
    last_valid = 1'b0;
  endtask

  task automatic random_steps(input int count, input int load_pct);
    bit          ld;
    logic [15:0] d;
    repeat (count) begin
      ld = ($urandom_range(0, 99) < load_pct);
      d  = ($urandom_range(0, 2) == 0) ? (16'($urandom) & 16'h00FF) : 16'($urandom);
      step(ld, d, 4'($urandom));
    end
  endtask

  initial begin
    bus.load    = 1'b0;
    bus.data_in = '0;
    bus.dp_in   = '0;
    @(negedge clk);
    do_reset(3);

    // Directed frames: start-of-frame load, mid-frame load, boundary load, follow-up loads.
    while (n < 8 * FRAME) begin
      case (n)
        0:             step(1'b1, 16'h1234, 4'b0000);
        2 * FRAME + 5: step(1'b1, 16'hAAAA, 4'b0000);
        4 * FRAME - 1: step(1'b1, 16'h0000, 4'b0000);
        4 * FRAME + 6: step(1'b1, 16'h5678, 4'b1001);
        5 * FRAME + 2: step(1'b1, 16'h0045, 4'b0000);
        6 * FRAME + 9: step(1'b1, 16'h0000, 4'b0100);
        default:       step(1'b0, 16'($urandom), 4'($urandom));
      endcase
    end

    random_steps(400, 6);

    // Reset mid-slot while a load is still pending.
    while ((n % FRAME) != 3) step(1'b0, 16'h0000, 4'b0000);
    step(1'b1, 16'hBEEF, 4'b1111);
    step(1'b0, 16'h0000, 4'b0000);
    do_reset(2);

    random_steps(3 * FRAME, 0);
    random_steps(200, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
